// File: rtl/inverse_permutation_unit_if.sv
// rtl/inverse_permutation_unit_if.sv - lane stream handshake bundle for the inverse permutation unit
interface inverse_permutation_unit_if #(
  parameter int W = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  // master feeds lanes in and drains lanes out; slave is the permutation unit
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/inverse_permutation_unit.sv
// rtl/inverse_permutation_unit.sv - serial-load, iterate inverse pi, serial-unload 5x5 lane state
module inverse_permutation_unit #(
  parameter int W      = 64,
  parameter int ROUNDS = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  inverse_permutation_unit_if.slave   bus,
  output logic                        busy
);

  localparam int RW = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {LOAD, PERM, UNLOAD} state_t;

  state_t         state;
  logic [4:0]     cnt;
  logic [RW-1:0]  rnd;
  logic [W-1:0]   lane [25];
  logic           in_ready_q;
  logic           out_valid_q;
  logic           busy_q;
  logic           accept;
  logic           take;

  assign accept = bus.in_valid & in_ready_q;
  assign take   = out_valid_q & bus.out_ready;

  // Sequencer: counters, state and the registered handshake/busy flags move together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= LOAD;
      cnt         <= '0;
      rnd         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (cnt == 5'd24) begin
              cnt        <= '0;
              rnd        <= '0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              state      <= PERM;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        PERM: begin
          // rnd counts completed rounds and parks at ROUNDS until the next load
          rnd <= rnd + 1'b1;
          if (rnd == RW'(ROUNDS - 1)) begin
            cnt         <= '0;
            out_valid_q <= 1'b1;
            state       <= UNLOAD;
          end
        end
        UNLOAD: begin
          if (take) begin
            if (cnt == 5'd24) begin
              cnt         <= '0;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
              state       <= LOAD;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  // Lane storage: serial write while loading, whole-state inverse pi each PERM cycle.
  // A'[x][y] = A[y][(2x+3y) mod 5]; all indices are elaboration-time constants.
  always_ff @(posedge clk) begin
    if (state == LOAD && accept) begin
      lane[cnt] <= bus.in_data;
    end else if (state == PERM) begin
      for (int x = 0; x < 5; x++) begin
        for (int y = 0; y < 5; y++) begin
          lane[x + 5 * y] <= lane[y + 5 * ((2 * x + 3 * y) % 5)];
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_valid_q && (cnt == 5'd24);
  assign bus.out_data  = out_valid_q ? lane[cnt] : '0;
  assign busy          = busy_q;

endmodule

// File: tb/tb_inverse_permutation_unit.sv
// tb/tb_inverse_permutation_unit.sv - directed bench for inverse_permutation_unit (ROUNDS=1/W=8 and ROUNDS=24/W=64)
module tb_inverse_permutation_unit;

  logic clk = 1'b0;
  logic rst;
  logic busy1;
  logic busy24;

  always #5 clk = ~clk;

  inverse_permutation_unit_if #(.W(8))  b1 ();
  inverse_permutation_unit_if #(.W(64)) b24 ();

  inverse_permutation_unit #(.W(8), .ROUNDS(1)) u_r1 (
    .clk  (clk),
    .rst  (rst),
    .bus  (b1),
    .busy (busy1)
  );

  inverse_permutation_unit #(.W(64), .ROUNDS(24)) u_r24 (
    .clk  (clk),
    .rst  (rst),
    .bus  (b24),
    .busy (busy24)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] src  [25];
  logic [63:0] orig [25];
  logic [63:0] got  [25];
  logic [63:0] tmp  [25];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_in(input int sel, input logic v, input logic [63:0] d);
    if (sel == 1) begin
      b1.in_valid = v;
      b1.in_data  = d[7:0];
    end else begin
      b24.in_valid = v;
      b24.in_data  = d;
    end
  endtask

  task automatic drive_ready(input int sel, input logic r);
    if (sel == 1) b1.out_ready = r;
    else          b24.out_ready = r;
  endtask

  task automatic sample(input int sel, output logic v, output logic [63:0] d,
                        output logic l, output logic b, output logic ir);
    if (sel == 1) begin
      v = b1.out_valid; d = {56'd0, b1.out_data}; l = b1.out_last; b = busy1; ir = b1.in_ready;
    end else begin
      v = b24.out_valid; d = b24.out_data; l = b24.out_last; b = busy24; ir = b24.in_ready;
    end
  endtask

  // src <= forward pi of orig: B[y][(2x+3y) mod 5] = A[x][y]
  task automatic forward_orig();
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        src[y + 5 * ((2 * x + 3 * y) % 5)] = orig[x + 5 * y];
  endtask

  // Feed src[0..24] starting at a negedge; optional in_valid gap after lane gap_lane.
  // Returns latency (cycles from lane-24 acceptance to first out_valid) and PERM busy cycles.
  task automatic load(input int sel, input int gap_lane, input int gap_len,
                      output int lat, output int busy_n);
    logic v, l, b, ir;
    logic [63:0] d;
    for (int i = 0; i < 25; i++) begin
      drive_in(sel, 1'b1, src[i]);
      sample(sel, v, d, l, b, ir);
      chk("load_in_ready", ir, 1'b1);
      @(negedge clk);
      if (i == gap_lane) begin
        drive_in(sel, 1'b0, 64'hdead);
        for (int g = 0; g < gap_len; g++) begin
          if (sel == 1) chk("gap_cnt_hold", {59'd0, u_r1.cnt}, gap_lane + 1);
          @(negedge clk);
        end
      end
    end
    // garbage on the input while permuting must be ignored
    drive_in(sel, 1'b1, {$urandom, $urandom});
    lat = 1;
    busy_n = 0;
    sample(sel, v, d, l, b, ir);
    while (!v && lat < 200) begin
      if (b) busy_n++;
      @(negedge clk);
      lat++;
      sample(sel, v, d, l, b, ir);
    end
    drive_in(sel, 1'b0, 64'd0);
  endtask

  // Drain lanes from the current negedge, optional 1,0,0,1 out_ready pattern.
  task automatic unload(input int sel, input bit bp, input int stop_at,
                        output int hs, output int busy_n);
    logic v, l, b, ir, rdy, stalled;
    logic [63:0] d, held;
    int cyc;
    hs = 0; busy_n = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (hs < stop_at && cyc < 400) begin
      rdy = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      drive_ready(sel, rdy);
      sample(sel, v, d, l, b, ir);
      if (b) busy_n++;
      if (stalled) begin
        chk("stall_valid", v, 1'b1);
        chk("stall_data", d, held);
      end
      if (v) begin
        chk("unload_in_ready", ir, 1'b0);
        if (rdy) begin
          got[hs] = d;
          chk("out_last", l, (hs == 24));
          hs++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = d;
        end
      end
      cyc++;
      @(negedge clk);
    end
    chk("handshakes", hs, stop_at);
    drive_ready(sel, 1'b1);
    if (stop_at == 25) begin
      sample(sel, v, d, l, b, ir);
      chk("post_out_valid", v, 1'b0);
      chk("post_in_ready", ir, 1'b1);
      chk("post_busy", b, 1'b0);
    end
  endtask

  initial begin
    int lat, bperm, hs, bun;
    logic v, l, b, ir;
    logic [63:0] d;

    rst = 1'b0;
    b1.in_valid = 1'b0;  b1.in_data = '0;  b1.out_ready = 1'b1;
    b24.in_valid = 1'b0; b24.in_data = '0; b24.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // reset state
    sample(1, v, d, l, b, ir);
    chk("rst_out_valid", v, 1'b0);
    chk("rst_out_last", l, 1'b0);
    chk("rst_out_data", d, 64'd0);
    chk("rst_busy", b, 1'b0);
    sample(24, v, d, l, b, ir);
    chk("rst24_out_valid", v, 1'b0);
    chk("rst24_out_data", d, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    sample(1, v, d, l, b, ir);
    chk("rel_in_ready", ir, 1'b1);

    // T1: ROUNDS=1, lane i = i
    for (int i = 0; i < 25; i++) src[i] = 64'(i);
    load(1, -1, 0, lat, bperm);
    chk("t1_latency", lat, 2);
    chk("t1_perm_busy", bperm, 1);
    unload(1, 1'b0, 25, hs, bun);
    chk("t1_lane0", got[0], 64'd0);
    chk("t1_lane1", got[1], 64'd10);
    chk("t1_lane2", got[2], 64'd20);
    chk("t1_lane3", got[3], 64'd5);
    chk("t1_lane4", got[4], 64'd15);
    chk("t1_lane5", got[5], 64'd16);
    chk("t1_lane6", got[6], 64'd1);
    chk("t1_unload_busy", bun, 25);
    // forward pi of the output must restore the identity state
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        tmp[y + 5 * ((2 * x + 3 * y) % 5)] = got[x + 5 * y];
    for (int i = 0; i < 25; i++) chk("t1_fwd_identity", tmp[i], 64'(i));

    // T2: ROUNDS=24, random lanes, pi^24 is identity; busy 24+25 cycles
    for (int i = 0; i < 25; i++) src[i] = {$urandom, $urandom};
    load(24, -1, 0, lat, bperm);
    chk("t2_latency", lat, 25);
    unload(24, 1'b0, 25, hs, bun);
    chk("t2_busy_total", bperm + bun, 49);
    for (int i = 0; i < 25; i++) chk("t2_lane", got[i], src[i]);

    // T3: ROUNDS=1 undoes forward pi; input gap after lane 7; backpressure on output
    for (int i = 0; i < 25; i++) orig[i] = 64'($urandom_range(0, 255));
    forward_orig();
    load(1, 7, 3, lat, bperm);
    chk("t3_latency", lat, 2);
    unload(1, 1'b1, 25, hs, bun);
    for (int i = 0; i < 25; i++) chk("t3_recover", got[i], orig[i]);
    chk("t3_lane0_fixed", got[0], src[0]);

    // T4: ROUNDS=24 with backpressure
    for (int i = 0; i < 25; i++) src[i] = {$urandom, $urandom};
    load(24, -1, 0, lat, bperm);
    unload(24, 1'b1, 25, hs, bun);
    for (int i = 0; i < 25; i++) chk("t4_lane", got[i], src[i]);

    // T5: reset while lane 12 is on the output, then a clean reload
    for (int i = 0; i < 25; i++) orig[i] = 64'($urandom_range(0, 255));
    forward_orig();
    load(1, -1, 0, lat, bperm);
    unload(1, 1'b0, 12, hs, bun);
    sample(1, v, d, l, b, ir);
    chk("t5_pre_valid", v, 1'b1);
    rst = 1'b0;
    #1;
    sample(1, v, d, l, b, ir);
    chk("t5_rst_valid", v, 1'b0);
    chk("t5_rst_busy", b, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sample(1, v, d, l, b, ir);
    chk("t5_rel_in_ready", ir, 1'b1);
    chk("t5_rel_valid", v, 1'b0);
    for (int i = 0; i < 25; i++) orig[i] = 64'($urandom_range(0, 255));
    forward_orig();
    load(1, -1, 0, lat, bperm);
    chk("t5_latency", lat, 2);
    unload(1, 1'b0, 25, hs, bun);
    for (int i = 0; i < 25; i++) chk("t5_fresh", got[i], orig[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inverse_permutation_unit.md
Name: inverse_permutation_unit

Overview:
- Inverse counterpart of the forward permutation unit: undoes the lane permutation that the forward round applies to a 5x5-lane state.
- Accepts a 25-lane state serially and applies the inverse pi round ROUNDS times, one round per cycle. Streams the result out serially.
- Sits on the decode/verification path after the forward permutation block and uses the same lane ordering.

Parameters:
- W, 64, lane width in bits.
- ROUNDS, 24, number of inverse rounds applied per state (>=1).

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input lane valid.
- in_ready  out  1  block accepts an input lane this cycle.
- in_data  in  W  input lane; lanes arrive in order i = x + 5y, i = 0..24.
- out_valid  out  1  output lane valid.
- out_ready  in  1  downstream accepts an output lane.
- out_data  out  W  output lane; sent in order i = 0..24.
- out_last  out  1  high with lane 24 of the output.
- busy  out  1  high in PERM and UNLOAD.

Behaviour:
- State storage: 25 x W register array. Lane counter: 5 bits. Round counter: clog2(ROUNDS+1) bits. One FSM with states LOAD, PERM, UNLOAD.
- Reset (rst=0, asynchronous):
  - FSM goes to LOAD; both counters clear to 0.
  - in_ready=1 once rst is released. out_valid=0, out_last=0, busy=0, out_data=0.
  - State array contents are don't-care.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: lane[cnt] <= in_data, cnt++.
  - When lane 24 is accepted: cnt <= 0, round counter <= 0, go to PERM.
  - in_valid low: hold. No timeout.
- PERM:
  - in_ready=0, busy=1.
  - Each cycle, every lane updates in parallel: A'[x][y] = A[y][(2x+3y) mod 5], index i = x + 5y.
  - Round counter increments each cycle. After exactly ROUNDS cycles, go to UNLOAD with cnt=0.
  - Latency: first output lane is valid ROUNDS+1 cycles after lane 24 is accepted.
- UNLOAD:
  - out_valid=1 and out_data=lane[cnt], registered-array read, no extra latency.
  - On out_valid&out_ready: cnt++.
  - out_last=1 exactly when cnt=24.
  - When lane 24 handshakes: out_valid=0, cnt <= 0, go to LOAD. in_ready rises the next cycle.
  - out_ready low: out_data and out_valid hold stable (AXI-style rule: valid never drops without a handshake).
- No overlap: a new input is not accepted until the previous output fully drains.
- Reset mid-operation (any state): immediate return to LOAD. A partially loaded or partially emitted state is discarded, and no further out_valid is driven.
- Arithmetic: all index math is mod 5 and fixed at elaboration; no runtime multipliers. Counters never wrap past 24 or ROUNDS.
- in_valid in PERM/UNLOAD is ignored; in_data is not sampled.

Test Plan:
- ROUNDS=1, W=8, input lane i = i, out_ready=1 -> outputs begin 0,10,20,5,15 (row y=0); output lane 6 = 1; output lane 5 = 16; out_last with lane 24; first out_valid 2 cycles after lane 24 accepted.
- ROUNDS=24, W=64, random lanes -> output equals input lane-for-lane (pi has order 24); busy high for exactly 24+25 cycles with out_ready=1.
- ROUNDS=1, apply the forward permutation in the bench model, feed the result in -> original state recovered; lane 0 always unchanged.
- Backpressure: out_ready toggles 1,0,0,1 pattern -> out_data and out_valid stable while stalled; 25 handshakes total; in_ready stays 0 until after the final handshake.
- Input gaps: in_valid low for 3 cycles after lane 7 -> counter holds at 8; final state unaffected.
- Reset asserted at output lane 12 -> out_valid=0 immediately; after release in_ready=1; a fresh load produces correct output with no stale lanes.
